// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU control path: sequencer states, opcode/funct
// field values and ULA operation codes.
package cpu_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC_R   = 4'd3,
    EXEC_I   = 4'd4,
    MEM_ADDR = 4'd5,
    MEM_RD   = 4'd6,
    MEM_WR   = 4'd7,
    WB_R     = 4'd8,
    WB_I     = 4'd9,
    WB_MEM   = 4'd10,
    BRANCH   = 4'd11,
    JUMP     = 4'd12,
    DONE     = 4'd13,
    TRAP     = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ULA_ADD = 3'b010;
  localparam logic [2:0] ULA_SUB = 3'b110;
  localparam logic [2:0] ULA_AND = 3'b000;
  localparam logic [2:0] ULA_OR  = 3'b001;
  localparam logic [2:0] ULA_SLT = 3'b111;

endpackage

// File: rtl/ula_decoder.sv
// Combinational R-type funct decoder; valid=0 flags an unsupported funct so the
// caller can trap. Shared with the single-cycle control unit.
module ula_decoder
  import cpu_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] ula_control,
  output logic       valid
);

  always_comb begin
    ula_control = ULA_ADD;
    valid       = 1'b1;
    case (funct)
      FUNCT_ADD: ula_control = ULA_ADD;
      FUNCT_SUB: ula_control = ULA_SUB;
      FUNCT_AND: ula_control = ULA_AND;
      FUNCT_OR:  ula_control = ULA_OR;
      FUNCT_SLT: ula_control = ULA_SLT;
      default:   valid       = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer: steps the datapath one enable per cycle, with run/single-step
// control, a mem req/ack handshake guarded by a timeout trap, and debug exports.
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             run,
  input  logic             step,
  input  logic             mem_ack,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic             reg_dst,
  output logic             ula_src,
  output logic [2:0]       ula_control,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_to_reg,
  output logic [3:0]       state_dbg,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state_reg, state_next;
  logic [5:0]       op_reg, funct_reg;
  logic             step_reg;
  logic [7:0]       wait_reg;
  logic [CNT_W-1:0] count_reg;
  logic             step_rise;
  logic             in_mem;
  logic [2:0]       dec_control;
  logic             dec_valid;

  assign step_rise = step & ~step_reg;
  assign in_mem    = (state_reg == MEM_RD) || (state_reg == MEM_WR);

  ula_decoder u_ula_decoder (
    .funct       (funct_reg),
    .ula_control (dec_control),
    .valid       (dec_valid)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (run || step_rise) state_next = FETCH;
      FETCH:    state_next = DECODE;
      DECODE: begin
        case (op)
          OP_RTYPE:     state_next = EXEC_R;
          OP_ADDI:      state_next = EXEC_I;
          OP_LW, OP_SW: state_next = MEM_ADDR;
          OP_BEQ:       state_next = BRANCH;
          OP_J:         state_next = JUMP;
          default:      state_next = TRAP;
        endcase
      end
      EXEC_R:   state_next = dec_valid ? WB_R : TRAP;
      EXEC_I:   state_next = WB_I;
      MEM_ADDR: state_next = (op_reg == OP_LW) ? MEM_RD : MEM_WR;
      // An ack in the last permitted cycle still completes the access.
      MEM_RD: begin
        if (mem_ack)                    state_next = WB_MEM;
        else if (wait_reg == WAIT_LAST) state_next = TRAP;
      end
      MEM_WR: begin
        if (mem_ack)                    state_next = DONE;
        else if (wait_reg == WAIT_LAST) state_next = TRAP;
      end
      WB_R, WB_I, WB_MEM, BRANCH, JUMP, DONE:
                state_next = run ? FETCH : IDLE;
      TRAP:     state_next = TRAP;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      op_reg    <= '0;
      funct_reg <= '0;
      step_reg  <= 1'b0;
      wait_reg  <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      step_reg  <= step;
      if (state_reg == DECODE) begin
        op_reg    <= op;
        funct_reg <= funct;
      end
      wait_reg <= (in_mem && state_next == state_reg) ? wait_reg + 8'd1 : 8'd0;
      if (pc_we) count_reg <= count_reg + CNT_W'(1);
    end
  end

  // Moore decode; pc_src in BRANCH follows zero, which the ULA produces that same cycle.
  always_comb begin
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_src      = 2'b00;
    reg_we      = 1'b0;
    reg_dst     = 1'b0;
    ula_src     = 1'b0;
    ula_control = ULA_ADD;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_to_reg  = 1'b0;
    halted      = 1'b0;
    case (state_reg)
      FETCH:  ir_we = 1'b1;
      EXEC_R: begin
        ula_src     = 1'b1;
        ula_control = dec_control;
      end
      // The ULA result feeds wd3 directly, so its operands stay selected through WB_R.
      WB_R: begin
        ula_src     = 1'b1;
        ula_control = dec_control;
        reg_we      = 1'b1;
        pc_we       = 1'b1;
      end
      WB_I: begin
        reg_we  = 1'b1;
        reg_dst = 1'b1;
        pc_we   = 1'b1;
      end
      MEM_RD: mem_req = 1'b1;
      MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
      end
      WB_MEM: begin
        reg_we     = 1'b1;
        reg_dst    = 1'b1;
        mem_to_reg = 1'b1;
        pc_we      = 1'b1;
      end
      BRANCH: begin
        ula_src     = 1'b1;
        ula_control = ULA_SUB;
        pc_src      = zero ? 2'b01 : 2'b00;
        pc_we       = 1'b1;
      end
      JUMP: begin
        pc_src = 2'b10;
        pc_we  = 1'b1;
      end
      DONE:   pc_we  = 1'b1;
      TRAP:   halted = 1'b1;
      default: ;
    endcase
  end

  assign state_dbg   = state_reg;
  assign instr_count = count_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle state/output tables for each
// instruction class, step/run control, memory wait, ack boundary and timeout trap.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op, funct;
  logic       zero, run, step, mem_ack;
  logic       ir_we, pc_we, reg_we, reg_dst, ula_src, mem_req, mem_we, mem_to_reg, halted;
  logic [1:0] pc_src;
  logic [2:0] ula_control;
  logic [3:0] state_dbg;
  logic [7:0] instr_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .run(run), .step(step),
    .mem_ack(mem_ack), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
    .reg_dst(reg_dst), .ula_src(ula_src), .ula_control(ula_control), .mem_req(mem_req),
    .mem_we(mem_we), .mem_to_reg(mem_to_reg), .state_dbg(state_dbg), .halted(halted),
    .instr_count(instr_count)
  );

  // {ir_we, pc_we, pc_src, reg_we, reg_dst, ula_src, ula_control, mem_req, mem_we, mem_to_reg, halted}
  wire [13:0] outs = {ir_we, pc_we, pc_src, reg_we, reg_dst, ula_src, ula_control,
                      mem_req, mem_we, mem_to_reg, halted};

  localparam logic [3:0] S_IDLE = 4'd0,  S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXR = 4'd3,
                         S_EXI  = 4'd4,  S_MADDR = 4'd5, S_MRD = 4'd6,    S_MWR = 4'd7,
                         S_WBR  = 4'd8,  S_WBI = 4'd9,   S_WBM = 4'd10,   S_BR = 4'd11,
                         S_J    = 4'd12, S_DONE = 4'd13, S_TRAP = 4'd14;

  localparam logic [13:0] O_IDLE    = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b010, 4'b0000};
  localparam logic [13:0] O_FETCH   = {1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b010, 4'b0000};
  localparam logic [13:0] O_EXR_SUB = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b110, 4'b0000};
  localparam logic [13:0] O_EXR_BAD = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b010, 4'b0000};
  localparam logic [13:0] O_WBR_SUB = {1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 3'b110, 4'b0000};
  localparam logic [13:0] O_WBI     = {1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 3'b010, 4'b0000};
  localparam logic [13:0] O_MRD     = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b010, 4'b1000};
  localparam logic [13:0] O_MWR     = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b010, 4'b1100};
  localparam logic [13:0] O_WBM     = {1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 3'b010, 4'b0010};
  localparam logic [13:0] O_DONE    = {1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'b010, 4'b0000};
  localparam logic [13:0] O_BR_T    = {1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 3'b110, 4'b0000};
  localparam logic [13:0] O_BR_N    = {1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 3'b110, 4'b0000};
  localparam logic [13:0] O_JUMP    = {1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 3'b010, 4'b0000};
  localparam logic [13:0] O_TRAP    = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b010, 4'b0001};

  task automatic test_reset;
    rst = 1'b1; run = 1'b0; step = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (state_dbg !== S_IDLE || outs !== O_IDLE || instr_count !== 8'd0) begin
      errors++;
      $display("FAIL reset: state=%0d outs=%b count=%0d, want state=%0d outs=%b count=0",
               state_dbg, outs, instr_count, S_IDLE, O_IDLE);
    end
    rst = 1'b0;
    $display("reset: state=%0d count=%0d", state_dbg, instr_count);
  endtask

  task automatic test_rtype_sub;
    logic [3:0]  es [5] = '{S_FETCH, S_DECODE, S_EXR, S_WBR, S_IDLE};
    logic [13:0] eo [5] = '{O_FETCH, O_IDLE, O_EXR_SUB, O_WBR_SUB, O_IDLE};
    run = 1'b1; op = 6'b000000; funct = 6'b100010;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (state_dbg !== es[i] || outs !== eo[i]) begin
        errors++;
        $display("FAIL sub cyc%0d: state=%0d outs=%b, want state=%0d outs=%b",
                 i, state_dbg, outs, es[i], eo[i]);
      end
      if (i == 3) run = 1'b0;
    end
    checks++;
    if (instr_count !== 8'd1) begin
      errors++;
      $display("FAIL sub count: got %0d want 1", instr_count);
    end
    $display("sub: count=%0d", instr_count);
  endtask

  task automatic test_async_reset;
    run = 1'b1; op = 6'b001000;
    @(posedge clk); #1;
    checks++;
    if (state_dbg !== S_FETCH || ir_we !== 1'b1) begin
      errors++;
      $display("FAIL arst pre: state=%0d ir_we=%b, want state=%0d ir_we=1", state_dbg, ir_we, S_FETCH);
    end
    run = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (state_dbg !== S_IDLE || outs !== O_IDLE || instr_count !== 8'd0) begin
      errors++;
      $display("FAIL arst: state=%0d outs=%b count=%0d, want state=0 outs=%b count=0",
               state_dbg, outs, instr_count, O_IDLE);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    $display("async reset mid-fetch: state=%0d count=%0d", state_dbg, instr_count);
  endtask

  task automatic test_step_addi;
    logic [3:0]  es [7] = '{S_FETCH, S_DECODE, S_EXI, S_WBI, S_IDLE, S_IDLE, S_IDLE};
    logic [13:0] eo [7] = '{O_FETCH, O_IDLE, O_IDLE, O_WBI, O_IDLE, O_IDLE, O_IDLE};
    logic        sv [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    run = 1'b0; op = 6'b001000; funct = 6'b000000; step = 1'b0;
    @(posedge clk); #1;
    step = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      checks++;
      if (state_dbg !== es[i] || outs !== eo[i]) begin
        errors++;
        $display("FAIL step cyc%0d: state=%0d outs=%b, want state=%0d outs=%b",
                 i, state_dbg, outs, es[i], eo[i]);
      end
      step = sv[i];
    end
    checks++;
    if (instr_count !== 8'd1) begin
      errors++;
      $display("FAIL step count: got %0d want 1", instr_count);
    end
    step = 1'b0;
    $display("step addi: count=%0d", instr_count);
  endtask

  task automatic test_lw_wait;
    logic [3:0]  es [8] = '{S_FETCH, S_DECODE, S_MADDR, S_MRD, S_MRD, S_MRD, S_WBM, S_IDLE};
    logic [13:0] eo [8] = '{O_FETCH, O_IDLE, O_IDLE, O_MRD, O_MRD, O_MRD, O_WBM, O_IDLE};
    int req_cycles = 0;
    int cyc = 1;
    bit seen = 0;
    run = 1'b1; op = 6'b100011; mem_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      checks++;
      if (state_dbg !== es[i] || outs !== eo[i]) begin
        errors++;
        $display("FAIL lw cyc%0d: state=%0d outs=%b, want state=%0d outs=%b",
                 i, state_dbg, outs, es[i], eo[i]);
      end
      if (mem_req) req_cycles++;
      if (!seen) cyc++;
      if (pc_we) seen = 1;
      run = 1'b0;
      mem_ack = (i == 5);
    end
    checks++;
    if (req_cycles != 3 || cyc != 8 || instr_count !== 8'd2) begin
      errors++;
      $display("FAIL lw totals: req=%0d cycles=%0d count=%0d, want req=3 cycles=8 count=2",
               req_cycles, cyc, instr_count);
    end
    $display("lw: req=%0d cycles=%0d count=%0d", req_cycles, cyc, instr_count);
  endtask

  task automatic test_sw_ack_boundary;
    logic [3:0]  es [13];
    logic [13:0] eo [13];
    int req_cycles = 0;
    es[0] = S_FETCH; es[1] = S_DECODE; es[2] = S_MADDR;
    eo[0] = O_FETCH; eo[1] = O_IDLE;   eo[2] = O_IDLE;
    for (int k = 3; k < 11; k++) begin es[k] = S_MWR; eo[k] = O_MWR; end
    es[11] = S_DONE; eo[11] = O_DONE; es[12] = S_IDLE; eo[12] = O_IDLE;
    run = 1'b1; op = 6'b101011; mem_ack = 1'b0;
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      checks++;
      if (state_dbg !== es[i] || outs !== eo[i]) begin
        errors++;
        $display("FAIL swack cyc%0d: state=%0d outs=%b, want state=%0d outs=%b",
                 i, state_dbg, outs, es[i], eo[i]);
      end
      if (mem_req) req_cycles++;
      run = 1'b0;
      mem_ack = (i == 10);
    end
    checks++;
    if (req_cycles != 8 || instr_count !== 8'd3) begin
      errors++;
      $display("FAIL swack totals: req=%0d count=%0d, want req=8 count=3", req_cycles, instr_count);
    end
    $display("sw ack on last wait cycle: req=%0d count=%0d", req_cycles, instr_count);
  endtask

  task automatic test_back_to_back;
    logic [3:0]  es [10] = '{S_FETCH, S_DECODE, S_BR, S_FETCH, S_DECODE, S_J,
                             S_FETCH, S_DECODE, S_BR, S_IDLE};
    logic [13:0] eo [10] = '{O_FETCH, O_IDLE, O_BR_T, O_FETCH, O_IDLE, O_JUMP,
                             O_FETCH, O_IDLE, O_BR_N, O_IDLE};
    run = 1'b1; op = 6'b000100; zero = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (state_dbg !== es[i] || outs !== eo[i]) begin
        errors++;
        $display("FAIL b2b cyc%0d: state=%0d outs=%b, want state=%0d outs=%b",
                 i, state_dbg, outs, es[i], eo[i]);
      end
      if (i == 3) op = 6'b000010;
      if (i == 6) op = 6'b000100;
      if (i == 7) zero = 1'b0;
      if (i == 8) run = 1'b0;
    end
    checks++;
    if (instr_count !== 8'd6) begin
      errors++;
      $display("FAIL b2b count: got %0d want 6", instr_count);
    end
    $display("beq/j/beq back-to-back: count=%0d", instr_count);
  endtask

  task automatic test_sw_timeout;
    logic [3:0]  es [14];
    logic [13:0] eo [14];
    int req_cycles = 0;
    int pc_we_cycles = 0;
    es[0] = S_FETCH; es[1] = S_DECODE; es[2] = S_MADDR;
    eo[0] = O_FETCH; eo[1] = O_IDLE;   eo[2] = O_IDLE;
    for (int k = 3; k < 11; k++) begin es[k] = S_MWR; eo[k] = O_MWR; end
    for (int k = 11; k < 14; k++) begin es[k] = S_TRAP; eo[k] = O_TRAP; end
    run = 1'b1; op = 6'b101011; mem_ack = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      checks++;
      if (state_dbg !== es[i] || outs !== eo[i]) begin
        errors++;
        $display("FAIL swto cyc%0d: state=%0d outs=%b, want state=%0d outs=%b",
                 i, state_dbg, outs, es[i], eo[i]);
      end
      if (mem_req) req_cycles++;
      if (pc_we) pc_we_cycles++;
      mem_ack = (i == 11);
      step = (i == 12);
    end
    checks++;
    if (req_cycles != 8 || pc_we_cycles != 0 || instr_count !== 8'd6 || halted !== 1'b1) begin
      errors++;
      $display("FAIL swto totals: req=%0d pc_we=%0d count=%0d halted=%b, want req=8 pc_we=0 count=6 halted=1",
               req_cycles, pc_we_cycles, instr_count, halted);
    end
    run = 1'b0; mem_ack = 1'b0; step = 1'b0;
    $display("sw timeout: req=%0d halted=%b count=%0d", req_cycles, halted, instr_count);
  endtask

  task automatic test_illegal;
    logic [3:0]  es [4];
    logic [13:0] eo [4];
    for (int pass = 0; pass < 2; pass++) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      es = '{S_FETCH, S_DECODE, S_TRAP, S_TRAP};
      eo = '{O_FETCH, O_IDLE, O_TRAP, O_TRAP};
      if (pass == 1) begin
        es = '{S_FETCH, S_DECODE, S_EXR, S_TRAP};
        eo = '{O_FETCH, O_IDLE, O_EXR_BAD, O_TRAP};
      end
      op = (pass == 0) ? 6'b111111 : 6'b000000;
      funct = 6'b111111;
      run = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #1;
        checks++;
        if (state_dbg !== es[i] || outs !== eo[i]) begin
          errors++;
          $display("FAIL illegal%0d cyc%0d: state=%0d outs=%b, want state=%0d outs=%b",
                   pass, i, state_dbg, outs, es[i], eo[i]);
        end
      end
      checks++;
      if (instr_count !== 8'd0) begin
        errors++;
        $display("FAIL illegal%0d count: got %0d want 0", pass, instr_count);
      end
      run = 1'b0;
      $display("illegal %s: state=%0d halted=%b", (pass == 0) ? "op" : "funct", state_dbg, halted);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rtype_sub();
    test_async_reset();
    test_step_addi();
    test_lw_wait();
    test_sw_ack_boundary();
    test_back_to_back();
    test_sw_timeout();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
